// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK bank driver.
//   jk_state_e : driver FSM states
//   attempt_w  : width of the attempt counter for a given retry budget
//   ATTEMPT_W  : attempt counter width for the default retry budget of 3
//   excite     : per-bit JK excitation, returns {j, k}
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } jk_state_e;

    // The counter must reach MAX_RETRY+1 (first pulse plus every retry).
    function automatic int attempt_w(input int max_retry);
        return $clog2(max_retry + 2);
    endfunction

    localparam int DEF_MAX_RETRY = 3;
    localparam int ATTEMPT_W     = attempt_w(DEF_MAX_RETRY);

    // Don't-cares resolved to 0, so J and K are never both high.
    function automatic logic [1:0] excite(input logic q, input logic q_next);
        return {~q & q_next, q & ~q_next};
    endfunction

endpackage

// File: rtl/jk_excite_lut.sv
// Combinational excitation table for a WIDTH-bit JK bank.
// Ports:
//   q      : current bank outputs
//   q_next : requested bank value
//   j, k   : per-bit excitation that moves q to q_next in one bank clock
module jk_excite_lut
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] q_next,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = excite(q[i], q_next[i]);
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives an external JK flip-flop bank to a requested word: pulses J/K for
// one cycle, waits for the bank to settle, reads it back, retries on a
// mismatch and reports done or err.
// Ports:
//   clk, reset          : system clock, asynchronous active-low reset
//   tgt_valid/tgt_ready : target handshake (ready only while idle)
//   tgt_data            : requested bank value
//   q_in                : bank outputs read back
//   j, k                : registered excitation to the bank
//   busy                : operation in progress
//   done, err           : one-cycle completion pulses
//   attempts            : excitation pulses used for the last/current target
//
// state  | meaning
// IDLE   | ready for a target, j/k held at 0
// DRIVE  | excitation on j/k for exactly one cycle
// SETTLE | j/k at 0, waiting out the bank gate delays
// CHECK  | last settle cycle; q_in compared at its closing edge
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tgt_valid,
    output logic                            tgt_ready,
    input  logic [WIDTH-1:0]                tgt_data,
    input  logic [WIDTH-1:0]                q_in,
    output logic [WIDTH-1:0]                j,
    output logic [WIDTH-1:0]                k,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [attempt_w(MAX_RETRY)-1:0] attempts
);

    localparam int AW = attempt_w(MAX_RETRY);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    jk_state_e        state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    att_q, att_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] lut_tgt;
    logic [WIDTH-1:0] lut_j;
    logic [WIDTH-1:0] lut_k;

    // One LUT serves both the first pulse (live tgt_data) and retries (latched target).
    assign lut_tgt = (state_q == IDLE) ? tgt_data : tgt_q;

    jk_excite_lut #(
        .WIDTH (WIDTH)
    ) u_lut (
        .q      (q_in),
        .q_next (lut_tgt),
        .j      (lut_j),
        .k      (lut_k)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        j_d     = j_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        att_d   = att_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                j_d = '0;
                k_d = '0;
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    j_d     = lut_j;
                    k_d     = lut_k;
                    att_d   = AW'(1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                j_d   = '0;
                k_d   = '0;
                cnt_d = CW'(SETTLE_CYCLES - 1);
                // SETTLE covers all settle cycles but the last; CHECK is the last one.
                state_d = (SETTLE_CYCLES == 1) ? CHECK : SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (q_in == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (att_q <= AW'(MAX_RETRY)) begin
                    j_d     = lut_j;
                    k_d     = lut_k;
                    att_d   = att_q + AW'(1);
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                j_d     = '0;
                k_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Async reset clears j/k at once so the bank is never excited during reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            att_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            att_q   <= att_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign attempts  = att_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
module tb_jk_bank_driver;

    logic                          clk;
    logic                          reset;
    logic                          tgt_valid;
    logic                          tgt_ready;
    logic [3:0]                    tgt_data;
    logic [3:0]                    q_in;
    logic [3:0]                    j;
    logic [3:0]                    k;
    logic                          busy;
    logic                          done;
    logic                          err;
    logic [jk_pkg::ATTEMPT_W-1:0]  attempts;

    int n_checks = 0;
    int n_errors = 0;

    // bank model controls
    logic       bank_load;
    logic [3:0] bank_load_val;
    logic       bank_stuck;
    int         ignore_n;
    logic [3:0] bank_q;
    int         pulse_cnt;

    jk_bank_driver #(
        .WIDTH         (4),
        .SETTLE_CYCLES (2),
        .MAX_RETRY     (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .q_in      (q_in),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .attempts  (attempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate-level JK bank on the same clock; can be stuck or ignore early pulses.
    always @(posedge clk) begin
        if (bank_load) begin
            bank_q    <= bank_load_val;
            pulse_cnt <= 0;
        end else if ((j | k) != 4'b0000) begin
            pulse_cnt <= pulse_cnt + 1;
            if (!bank_stuck && pulse_cnt >= ignore_n)
                bank_q <= (j & ~bank_q) | (~k & bank_q);
        end
    end
    assign q_in = bank_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_bank(input logic [3:0] v);
        bank_load     = 1'b1;
        bank_load_val = v;
        step(1);
        bank_load     = 1'b0;
    endtask

    // Returns at the negedge inside the DRIVE cycle (index 0).
    task automatic accept(input logic [3:0] d);
        check_eq("ready_before_accept", {31'd0, tgt_ready}, 32'd1);
        tgt_valid = 1'b1;
        tgt_data  = d;
        step(1);
        tgt_valid = 1'b0;
    endtask

    // Observes from the current cycle (index 0) until done or err.
    task automatic run_to_end(input int limit, output int lat, output int pulses,
                              output logic saw_done, output logic saw_err,
                              output logic finished);
        lat      = 0;
        pulses   = 0;
        saw_done = 1'b0;
        saw_err  = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((j | k) != 4'b0000) pulses++;
            if (done) saw_done = 1'b1;
            if (err)  saw_err  = 1'b1;
            if (done || err) begin
                lat      = i;
                finished = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    int   lat;
    int   pulses;
    logic sd, se, fin;

    initial begin
        reset         = 1'b0;
        tgt_valid     = 1'b0;
        tgt_data      = 4'b0000;
        bank_load     = 1'b1;
        bank_load_val = 4'b0000;
        bank_stuck    = 1'b0;
        ignore_n      = 0;

        // 1: reset state
        step(1);
        check_eq("rst_j",        {28'd0, j}, 32'h0);
        check_eq("rst_k",        {28'd0, k}, 32'h0);
        check_eq("rst_ready",    {31'd0, tgt_ready}, 32'd1);
        check_eq("rst_busy",     {31'd0, busy}, 32'd0);
        check_eq("rst_attempts", {29'd0, attempts}, 32'd0);
        check_eq("rst_done_err", {30'd0, done, err}, 32'd0);
        bank_load = 1'b0;
        reset     = 1'b1;
        step(1);

        // 1b: reset mid-DRIVE clears j/k without a clock edge
        accept(4'b0110);
        check_eq("mid_drive_j", {28'd0, j}, 32'h6);
        #2 reset = 1'b0;
        #1;
        check_eq("async_clr_j",    {28'd0, j}, 32'h0);
        check_eq("async_clr_k",    {28'd0, k}, 32'h0);
        check_eq("async_clr_busy", {31'd0, busy}, 32'd0);
        step(1);
        check_eq("rst_hold_done_err", {30'd0, done, err}, 32'd0);
        check_eq("rst_hold_attempts", {29'd0, attempts}, 32'd0);
        reset = 1'b1;
        step(1);
        check_eq("post_rst_done_err", {30'd0, done, err}, 32'd0);
        check_eq("post_rst_bank",     {28'd0, q_in}, 32'h0);

        // 2: 0101 -> 0011, single attempt
        load_bank(4'b0101);
        accept(4'b0011);
        check_eq("t2_j",     {28'd0, j}, 32'h2);
        check_eq("t2_k",     {28'd0, k}, 32'h4);
        check_eq("t2_busy",  {31'd0, busy}, 32'd1);
        check_eq("t2_ready", {31'd0, tgt_ready}, 32'd0);
        step(1);
        check_eq("t2_settle_jk", {24'd0, j, k}, 32'h0);
        step(1);
        check_eq("t2_no_early_done", {31'd0, done}, 32'd0);
        step(1);
        check_eq("t2_done",     {31'd0, done}, 32'd1);
        check_eq("t2_attempts", {29'd0, attempts}, 32'd1);
        check_eq("t2_ready_in_done", {31'd0, tgt_ready}, 32'd1);
        check_eq("t2_bank",     {28'd0, q_in}, 32'h3);
        step(1);
        check_eq("t2_done_one_cycle", {30'd0, done, err}, 32'd0);
        check_eq("t2_attempts_hold",  {29'd0, attempts}, 32'd1);

        // 3: bank ignores first pulse, 0000 -> 1111
        ignore_n = 1;
        load_bank(4'b0000);
        accept(4'b1111);
        check_eq("t3_j1", {28'd0, j}, 32'hf);
        step(3);
        check_eq("t3_j2",        {28'd0, j}, 32'hf);
        check_eq("t3_k2",        {28'd0, k}, 32'h0);
        check_eq("t3_attempts2", {29'd0, attempts}, 32'd2);
        check_eq("t3_no_done",   {30'd0, done, err}, 32'd0);
        step(3);
        check_eq("t3_done",     {31'd0, done}, 32'd1);
        check_eq("t3_attempts", {29'd0, attempts}, 32'd2);
        check_eq("t3_bank",     {28'd0, q_in}, 32'hf);
        ignore_n = 0;
        step(1);

        // 4: stuck bank, retries exhausted
        bank_stuck = 1'b1;
        load_bank(4'b0000);
        accept(4'b1000);
        run_to_end(40, lat, pulses, sd, se, fin);
        check_eq("t4_finished", {31'd0, fin}, 32'd1);
        check_eq("t4_latency",  lat, 32'd12);
        check_eq("t4_pulses",   pulses, 32'd4);
        check_eq("t4_err",      {31'd0, se}, 32'd1);
        check_eq("t4_no_done",  {31'd0, sd}, 32'd0);
        check_eq("t4_attempts", {29'd0, attempts}, 32'd4);
        step(1);
        check_eq("t4_err_one_cycle", {30'd0, done, err}, 32'd0);
        bank_stuck = 1'b0;

        // 5: target equals current bank value
        load_bank(4'b1010);
        accept(4'b1010);
        check_eq("t5_jk", {24'd0, j, k}, 32'h0);
        run_to_end(20, lat, pulses, sd, se, fin);
        check_eq("t5_latency",  lat, 32'd3);
        check_eq("t5_pulses",   pulses, 32'd0);
        check_eq("t5_done",     {30'd0, sd, se}, 32'd2);
        check_eq("t5_attempts", {29'd0, attempts}, 32'd1);
        step(1);

        // 6: back-to-back with tgt_valid held high
        load_bank(4'b0000);
        tgt_valid = 1'b1;
        tgt_data  = 4'b0001;
        step(1);
        tgt_data  = 4'b1000;
        check_eq("t6_a_j", {28'd0, j}, 32'h1);
        step(1);
        check_eq("t6_busy_ignore", {31'd0, tgt_ready}, 32'd0);
        step(2);
        check_eq("t6_a_done",  {31'd0, done}, 32'd1);
        check_eq("t6_a_bank",  {28'd0, q_in}, 32'h1);
        check_eq("t6_a_ready", {31'd0, tgt_ready}, 32'd1);
        step(1);
        check_eq("t6_b_j",        {28'd0, j}, 32'h8);
        check_eq("t6_b_k",        {28'd0, k}, 32'h1);
        check_eq("t6_b_busy",     {31'd0, busy}, 32'd1);
        check_eq("t6_b_attempts", {29'd0, attempts}, 32'd1);
        tgt_data = 4'b0111;
        step(1);
        tgt_valid = 1'b0;
        check_eq("t6_b_settle_jk", {24'd0, j, k}, 32'h0);
        step(2);
        check_eq("t6_b_done", {31'd0, done}, 32'd1);
        check_eq("t6_b_bank", {28'd0, q_in}, 32'h8);
        step(1);
        check_eq("t6_no_extra_accept", {31'd0, busy}, 32'd0);
        check_eq("t6_idle_jk",         {24'd0, j, k}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Synchronous driver that moves an external bank of gate-level JK flip-flops to a requested target word. It converts each target into per-bit J/K excitation and pulses it for one cycle. It then waits for the bank's gate delays to settle, reads the bank outputs back, and retries on mismatch. It sits between a valid/ready command source and the JK register bank, acting as the writer for that bank.

## Interface
Parameters:
- WIDTH, 4, number of JK flip-flops in the bank (≥1)
- SETTLE_CYCLES, 2, idle cycles between excitation pulse and readback (≥1)
- MAX_RETRY, 3, re-excitation attempts after the first before error (≥0)

Ports:
- clk  input  1  system clock; the JK bank is clocked by the same clk
- reset  input  1  asynchronous, active-low reset
- tgt_valid  input  1  target word offered
- tgt_ready  output  1  driver can accept a target (high only in IDLE)
- tgt_data  input  WIDTH  requested bank value
- q_in  input  WIDTH  bank outputs (out of each flip-flop), same clock domain
- j  output  WIDTH  J excitation to the bank, registered
- k  output  WIDTH  K excitation to the bank, registered
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse: bank matches target
- err  output  1  one-cycle pulse: retries exhausted without a match
- attempts  output  clog2(MAX_RETRY+2)  excitation pulses used for the last/current target

## Operation
- The excitation table is per bit, with don't-cares resolved to 0:
  - q=0→0: J=0, K=0
  - q=0→1: J=1, K=0
  - q=1→0: J=0, K=1
  - q=1→1: J=0, K=0
  - J and K are never both 1.
- The FSM has four states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - tgt_ready=1. j and k are held at 0.
  - On tgt_valid&&tgt_ready, latch tgt_data into the target register, load j/k = excite(q_in, tgt_data), set attempts=1, and go to DRIVE.
- DRIVE:
  - j/k hold their values for exactly one cycle.
  - Next edge: j/k←0, settle counter←SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - Count down; at 0, go to CHECK.
- CHECK, which samples q_in:
  - If q_in==target: pulse done and go to IDLE.
  - Else if attempts ≤ MAX_RETRY: j/k←excite(q_in, target), attempts+1, go to DRIVE.
  - Else: pulse err and go to IDLE.
- attempts holds its value in IDLE until the next acceptance.
- A target equal to the current q_in still runs the full sequence, with j=k=0; done follows at normal latency.
- tgt_valid while busy is ignored. Changes to tgt_data after acceptance have no effect.

## Timing
- All outputs are registered except tgt_ready and busy, which decode from the state register.
- Reset values:
  - State IDLE; j=0, k=0, done=0, err=0, attempts=0.
  - tgt_ready=1, busy=0.
- When reset is asserted, j/k go to 0 immediately, without waiting for a clock edge. This guarantees the bank is never excited during reset.
- Acceptance at edge E0:
  - j/k are valid in cycle [E0,E1).
  - The SETTLE cycles follow, then CHECK samples q_in at edge E(1+SETTLE_CYCLES).
  - done/err is high in cycle [E(1+S), E(2+S)).
  - tgt_ready returns to 1 in the same cycle that done/err is high, so back-to-back acceptance is possible at E(2+S).
- Each retry adds 1+SETTLE_CYCLES cycles.
- done and err are mutually exclusive and never high for more than one cycle.
- Reset mid-operation: the in-flight target is dropped, with no done or err pulse. After reset release, the next accepted target starts from attempts=1.

## Structure
- Package jk_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, CHECK)
  - constant ATTEMPT_W
  - function excite(q, q_next) returning {j,k}
- One sub-module, jk_excite_lut: purely combinational, WIDTH-wide q/target to j/k, instantiated once. The FSM registers its output.

## Test plan
1. Reset with q_in=4'b0000, tgt_valid=0. During reset j=k=0, tgt_ready=1, attempts=0; reset is asserted mid-DRIVE and j/k clear without a clock edge.
2. With q_in=4'b0101, accept tgt_data=4'b0011. In the DRIVE cycle j=4'b0010, k=4'b0100. Model bank updates q_in=4'b0011. done is high exactly 3 cycles after acceptance (S=2), attempts=1.
3. Model bank ignores the first pulse (q_in stays 4'b0000, target 4'b1111). Second DRIVE reissues j=4'b1111, k=0. Bank then responds, and done arrives with attempts=2 at acceptance+6.
4. Stuck bank (q_in fixed 4'b0000, target 4'b1000, MAX_RETRY=3). Four DRIVE pulses occur, then err pulses once with attempts=4, and done never asserts.
5. Target equals q_in=4'b1010. j=k=0 throughout, and done arrives at acceptance+3.
6. Back-to-back: tgt_valid held high with 4'b0001 then 4'b1000. The second acceptance occurs in the done cycle of the first. tgt_valid pulses while busy are not accepted.
